// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator controller: key codes,
// ALU operation encoding and controller FSM states.
package calc_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_ADD       = 4'hA;
    localparam logic [3:0] KEY_SUB       = 4'hB;
    localparam logic [3:0] KEY_MUL       = 4'hC;
    localparam logic [3:0] KEY_EQ        = 4'hD;
    localparam logic [3:0] KEY_CLEAR     = 4'hE;
    localparam logic [3:0] KEY_DEL       = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam logic [1:0] MAX_DIGITS = 2'd3;

    typedef enum logic [1:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_WAIT_ALU,
        ST_SHOW_RES
    } calc_state_t;

    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        case (key)
            KEY_ADD: key_to_op = OP_ADD;
            KEY_SUB: key_to_op = OP_SUB;
            default: key_to_op = OP_MUL;
        endcase
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// 3-digit BCD entry register: push shifts a digit in at the LSD, pop shifts right.
// Latency: one cycle from control to value/count.
// Backpressure: none; push when full and pop when empty are silently dropped.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic        push,
    input  logic        pop,
    input  logic [3:0]  digit,
    output logic [11:0] value,
    output logic [1:0]  count
);

    // load = clear followed by a push of the first digit, in one cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= 12'h000;
            count <= 2'd0;
        end else if (load) begin
            value <= {8'h00, digit};
            count <= 2'd1;
        end else if (push && count != MAX_DIGITS) begin
            value <= {value[7:0], digit};
            count <= count + 2'd1;
        end else if (pop && count != 2'd0) begin
            value <= {4'h0, value[11:4]};
            count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/control_calc.sv
// Keypad calculator controller: builds BCD operands, launches the ALU, shows result.
// Latency: every key/alu_done takes effect on the following clock edge.
// Backpressure: keys arriving while the ALU is busy are dropped.
module control_calc
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_error,
    output logic [11:0] operand_a,
    output logic [11:0] operand_b,
    output logic [1:0]  op_sel,
    output logic        alu_start,
    output logic [15:0] display,
    output logic        error,
    output logic        busy
);

    calc_state_t state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic        start_q, start_d;

    logic        a_clr, a_load, a_push, a_pop;
    logic        b_clr, b_push, b_pop;
    logic [1:0]  a_cnt, b_cnt;
    logic        is_digit, is_op;

    assign is_digit = (key_code <= KEY_MAX_DIGIT);
    assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MUL);

    bcd_entry_reg u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (a_clr),
        .load  (a_load),
        .push  (a_push),
        .pop   (a_pop),
        .digit (key_code),
        .value (operand_a),
        .count (a_cnt)
    );

    bcd_entry_reg u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (b_clr),
        .load  (1'b0),
        .push  (b_push),
        .pop   (b_pop),
        .digit (key_code),
        .value (operand_b),
        .count (b_cnt)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        start_d = 1'b0;
        a_clr   = 1'b0;
        a_load  = 1'b0;
        a_push  = 1'b0;
        a_pop   = 1'b0;
        b_clr   = 1'b0;
        b_push  = 1'b0;
        b_pop   = 1'b0;

        if (state_q == ST_WAIT_ALU) begin
            // keys are dropped here, even when they coincide with alu_done
            if (alu_done) begin
                res_d   = alu_result;
                err_d   = alu_error;
                state_d = ST_SHOW_RES;
            end
        end else if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                a_clr   = 1'b1;
                b_clr   = 1'b1;
                op_d    = OP_ADD;
                err_d   = 1'b0;
                state_d = ST_ENTER_A;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        a_push = is_digit && (a_cnt != MAX_DIGITS);
                        a_pop  = (key_code == KEY_DEL) && (a_cnt != 2'd0);
                        if (is_op) begin
                            op_d    = key_to_op(key_code);
                            state_d = ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        b_push = is_digit;
                        b_pop  = (key_code == KEY_DEL);
                        // operator may be changed only before B has any digit
                        if (is_op && b_cnt == 2'd0) begin
                            op_d = key_to_op(key_code);
                        end
                        if (key_code == KEY_EQ) begin
                            start_d = 1'b1;
                            state_d = ST_WAIT_ALU;
                        end
                    end
                    ST_SHOW_RES: begin
                        if (is_digit) begin
                            a_load  = 1'b1;
                            b_clr   = 1'b1;
                            err_d   = 1'b0;
                            state_d = ST_ENTER_A;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENTER_A;
            op_q    <= OP_ADD;
            res_q   <= 16'h0000;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_ENTER_A:  display = {4'h0, operand_a};
            ST_SHOW_RES: display = res_q;
            default:     display = {4'h0, operand_b};
        endcase
    end

    assign op_sel    = op_q;
    assign alu_start = start_q;
    assign error     = err_q;
    assign busy      = (state_q == ST_WAIT_ALU);

endmodule

// File: tb/tb_control_calc.sv
// Bench for control_calc: directed key sequences with literal expectations,
// then randomized keys/ALU responses checked every cycle against a decimal model.
module tb_control_calc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0;
    logic        alu_error = 1'b0;
    logic [11:0] operand_a, operand_b;
    logic [1:0]  op_sel;
    logic        alu_start, error, busy;
    logic [15:0] display;

    int vectors = 0;
    int miscompares = 0;

    control_calc dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op_sel     (op_sel),
        .alu_start  (alu_start),
        .display    (display),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: operands held as decimal integers with a digit count.
    localparam int M_A = 0, M_B = 1, M_WAIT = 2, M_SHOW = 3;
    int          m_mode = M_A;
    int          m_a = 0, m_acnt = 0, m_b = 0, m_bcnt = 0;
    int          m_op = 0;
    logic        m_err = 1'b0;
    logic        m_start = 1'b0;
    logic [15:0] m_res = 16'h0;

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = 16'((((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic model_clear();
        m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0; m_op = 0; m_err = 1'b0;
    endtask

    task automatic model_update(input logic r, input logic kv, input int kc,
                                input logic dn, input logic [15:0] res, input logic er);
        m_start = 1'b0;
        if (r) begin
            model_clear();
            m_res = 16'h0;
            m_mode = M_A;
        end else if (m_mode == M_WAIT) begin
            if (dn) begin
                m_res = res;
                m_err = er;
                m_mode = M_SHOW;
            end
        end else if (kv) begin
            if (kc == 14) begin
                model_clear();
                m_mode = M_A;
            end else if (m_mode == M_A) begin
                if (kc <= 9 && m_acnt < 3) begin m_a = m_a * 10 + kc; m_acnt++; end
                else if (kc == 15 && m_acnt > 0) begin m_a = m_a / 10; m_acnt--; end
                else if (kc >= 10 && kc <= 12) begin m_op = kc - 10; m_mode = M_B; end
            end else if (m_mode == M_B) begin
                if (kc <= 9 && m_bcnt < 3) begin m_b = m_b * 10 + kc; m_bcnt++; end
                else if (kc == 15 && m_bcnt > 0) begin m_b = m_b / 10; m_bcnt--; end
                else if (kc >= 10 && kc <= 12 && m_bcnt == 0) m_op = kc - 10;
                else if (kc == 13) begin m_start = 1'b1; m_mode = M_WAIT; end
            end else begin
                if (kc <= 9) begin
                    m_a = kc; m_acnt = 1; m_b = 0; m_bcnt = 0; m_err = 1'b0;
                    m_mode = M_A;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [15:0] exp_disp;
        exp_disp = (m_mode == M_SHOW) ? m_res : (m_mode == M_A) ? to_bcd(m_a) : to_bcd(m_b);
        cmp("operand_a", {4'h0, operand_a}, to_bcd(m_a));
        cmp("operand_b", {4'h0, operand_b}, to_bcd(m_b));
        cmp("op_sel", {14'h0, op_sel}, 16'(m_op));
        cmp("alu_start", {15'h0, alu_start}, {15'h0, m_start});
        cmp("display", display, exp_disp);
        cmp("error", {15'h0, error}, {15'h0, m_err});
        cmp("busy", {15'h0, busy}, {15'h0, (m_mode == M_WAIT)});
    endtask

    task automatic step(input logic r, input logic kv, input logic [3:0] kc,
                        input logic dn, input logic [15:0] res, input logic er);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc;
        alu_done = dn; alu_result = res; alu_error = er;
        @(posedge clk);
        model_update(r, kv, int'(kc), dn, res, er);
        #1;
        compare_all();
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b0, 1'b1, kc, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 4'h1, 1'b1, 16'h1234, 1'b1);
        cmp("rst_display", display, 16'h0000);
        cmp("rst_busy", {15'h0, busy}, 16'h0);
        cmp("rst_operand_a", {4'h0, operand_a}, 16'h0000);

        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        cmp("a_123", {4'h0, operand_a}, 16'h0123);
        cmp("disp_0123", display, 16'h0123);

        key(4'hE);
        key(4'h7); key(4'hA); key(4'h8); key(4'hD);
        cmp("start_after_D", {15'h0, alu_start}, 16'h1);
        cmp("busy_after_D", {15'h0, busy}, 16'h1);
        cmp("b_008", {4'h0, operand_b}, 16'h0008);
        cmp("op_add", {14'h0, op_sel}, 16'h0);
        idle();
        cmp("start_one_cycle", {15'h0, alu_start}, 16'h0);

        step(1'b0, 1'b1, 4'hE, 1'b1, 16'h0015, 1'b0);
        cmp("show_0015", display, 16'h0015);
        cmp("a_kept_007", {4'h0, operand_a}, 16'h0007);
        cmp("b_kept_008", {4'h0, operand_b}, 16'h0008);

        key(4'hE);
        key(4'h5); key(4'h6); key(4'hF);
        cmp("del_005", {4'h0, operand_a}, 16'h0005);
        key(4'hF);
        cmp("del_000", {4'h0, operand_a}, 16'h0000);
        key(4'hF);
        key(4'h1); key(4'h2); key(4'h3);
        cmp("count_zero_after_del", {4'h0, operand_a}, 16'h0123);

        key(4'hE);
        key(4'h2); key(4'hB); key(4'hC); key(4'h3);
        cmp("op_replaced_mul", {14'h0, op_sel}, 16'h2);
        key(4'hA);
        cmp("op_locked_mul", {14'h0, op_sel}, 16'h2);

        key(4'hD);
        cmp("busy_before_rst", {15'h0, busy}, 16'h1);
        step(1'b1, 1'b0, 4'h0, 1'b1, 16'h0777, 1'b1);
        cmp("rst_mid_wait_busy", {15'h0, busy}, 16'h0);
        cmp("rst_mid_wait_b", {4'h0, operand_b}, 16'h0000);
        step(1'b0, 1'b0, 4'h0, 1'b1, 16'h0999, 1'b1);
        cmp("late_done_ignored", display, 16'h0000);
        cmp("late_done_err", {15'h0, error}, 16'h0);

        for (int i = 0; i < 4000; i++) begin
            logic r, kv, dn, er;
            logic [3:0] kc;
            logic [15:0] res;
            r   = ($urandom_range(0, 199) == 0);
            kv  = ($urandom_range(0, 2) != 0);
            kc  = 4'($urandom_range(0, 15));
            dn  = ($urandom_range(0, 5) == 0);
            er  = 1'($urandom);
            res = 16'($urandom);
            step(r, kv, kc, dn, res, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_calc.md
CONTROL_CALC -- requirements
Module: control_calc

Interface
REQ-001 Ports SHALL be: clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 key_valid  in  1  one-cycle pulse; a translated key is present this cycle.
REQ-004 key_code  in  4  translated key: 0000-1001 digits 0-9, 1010 A (add), 1011 B (sub), 1100 C (mul), 1110 '*' (clear all), 1111 '#' (delete digit), 1101 D (equals).
REQ-005 alu_done  in  1  one-cycle pulse; alu_result/alu_error valid.
REQ-006 alu_result  in  16  4-digit BCD result.
REQ-007 alu_error  in  1  overflow/negative flag, qualified by alu_done.
REQ-008 operand_a  out  12  3-digit BCD operand A.
REQ-009 operand_b  out  12  3-digit BCD operand B.
REQ-010 op_sel  out  2  00 add, 01 sub, 10 mul; stable while alu_start/busy.
REQ-011 alu_start  out  1  one-cycle pulse requesting computation.
REQ-012 display  out  16  4-digit BCD value to show.
REQ-013 error  out  1  latched alu_error of last result.
REQ-014 busy  out  1  high in WAIT_ALU.

Function
REQ-015 FSM states SHALL be ENTER_A, ENTER_B, WAIT_ALU, SHOW_RES.
REQ-016 Every key SHALL take effect one cycle after its key_valid (registered; outputs update at N+1).
REQ-017 Digit entry SHALL shift left by one BCD digit, new digit into LSD; count per operand 0-3; 4th digit SHALL be ignored; leading zeros count as digits.
REQ-018 '#' SHALL shift the current operand right one digit and decrement count; at count 0 no change.
REQ-019 '*' SHALL, in any state except WAIT_ALU, clear A, B, counts, op_sel, error and go to ENTER_A.
REQ-020 ENTER_A: operator key latches op_sel, goes to ENTER_B (A=000 if no digits); D ignored.
REQ-021 ENTER_B: operator with B count 0 replaces op_sel; with count >0 ignored; D asserts alu_start for exactly one cycle (N+1) and enters WAIT_ALU (B=000 if no digits).
REQ-022 WAIT_ALU: all keys ignored, including '*'; on alu_done latch alu_result into result register and alu_error into error, go to SHOW_RES.
REQ-023 alu_done and key_valid in the same WAIT_ALU cycle: done processed, key dropped.
REQ-024 SHOW_RES: digit clears A/B/error, loads digit as first A digit, goes to ENTER_A; operator, '#', D ignored.
REQ-025 display SHALL be {0000,A} in ENTER_A, {0000,B} in ENTER_B and WAIT_ALU, result register in SHOW_RES.
REQ-026 operand_a, operand_b, op_sel SHALL not change between alu_start and alu_done.
REQ-027 alu_done outside WAIT_ALU SHALL be ignored.
REQ-028 Undefined key codes SHALL not exist (all 16 mapped); no key SHALL produce more than one action.

Reset
REQ-029 rst SHALL force state ENTER_A, operand_a/b 000, counts 0, op_sel 00, alu_start 0, display 0000, error 0, busy 0 at next edge, overriding key_valid and alu_done, including mid WAIT_ALU.

Structure
REQ-030 Shared package calc_pkg SHALL hold key-code constants, op_sel encoding and the FSM state enum.
REQ-031 One sub-module bcd_entry_reg (3-digit BCD shift register with count, push/pop/clear/load) SHALL be instantiated twice, for A and B.

Verification
REQ-032 Keys 1,2,3,4 -> operand_a 0x123, display 0x0123, 4 ignored.
REQ-033 Keys 7,A,8,D -> op_sel 00, operand_b 0x008, single alu_start pulse one cycle after D, busy high.
REQ-034 In WAIT_ALU send '*' and alu_done together (alu_result 0x0015) -> SHOW_RES, display 0x0015, A/B unchanged.
REQ-035 Keys 5,6,#,# then # -> operand_a 0x005 then 0x000, count stays 0 on third #.
REQ-036 Keys 2,B,C,3 -> op_sel 10; then A ignored after digit 3.
REQ-037 rst asserted in WAIT_ALU -> next cycle all outputs at reset values, later alu_done ignored.
